// File: rtl/uarttx_pkg.sv
// -----------------------------------------------------------------------------
// uarttx_pkg
// Shared definitions for the memory-mapped 8N1 UART transmitter:
//   - transmit FSM state encoding
//   - register word offsets (address bit 1)
//   - CTRL and STATUS bit positions
//   - parity helper
// Optional feature macro: UARTTX_PARITY_EN (adds the PARITY state).
// -----------------------------------------------------------------------------
package uarttx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef UARTTX_PARITY_EN
        ST_PARITY = 3'd4,
`endif
        ST_STOP   = 3'd3
    } tx_state_e;

    // Word offset within the register block, selected by address bit 1.
    localparam logic OFF_DATA = 1'b0;   // DATA (lane 0) / CTRL (lane 1)
    localparam logic OFF_DIV  = 1'b1;   // DIV[7:0] (lane 0) / DIV[15:8] (lane 1)

    // CTRL byte bit positions.
    localparam int CTRL_TXEN    = 0;
    localparam int CTRL_IE      = 1;
    localparam int CTRL_PEN     = 2;
    localparam int CTRL_ODD     = 3;
    localparam int CTRL_OVF_CLR = 7;    // write-one-to-clear OVF, never stored

    // STATUS byte bit positions.
    localparam int STAT_NOT_FULL = 0;
    localparam int STAT_EMPTY    = 1;
    localparam int STAT_IDLE     = 2;
    localparam int STAT_OVF      = 3;

    // Even parity of the byte, inverted for odd parity.
    function automatic logic parity_of(input logic [7:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uarttx_fifo.sv
// -----------------------------------------------------------------------------
// uarttx_fifo
// Synchronous circular-buffer FIFO. Pointers carry one extra wrap bit so that
// full and empty are distinguishable. Read data is presented combinationally
// from the head entry so a pop can capture it on the same edge.
// A push while full is accepted only if a pop happens in the same cycle.
// Ports:
//   clk      - clock, all state on posedge
//   reset    - asynchronous, active-low
//   push_i   - write request (wdata_i)
//   pop_i    - remove head entry (ignored when empty)
//   wdata_i  - data to push
//   rdata_o  - head entry
//   full_o   - no free entries
//   empty_o  - no stored entries
// -----------------------------------------------------------------------------
module uarttx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0] entry_we;
    logic [AW-1:0]    wr_idx, rd_idx;
    logic             do_push, do_pop;

    assign wr_idx  = wr_ptr_q[AW-1:0];
    assign rd_idx  = rd_ptr_q[AW-1:0];

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_idx == rd_idx);

    assign do_pop  = pop_i & ~empty_o;
    // A simultaneous pop frees the slot the push needs.
    assign do_push = push_i & (~full_o | do_pop);

    assign wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    assign rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_we
            assign entry_we[gi] = do_push && (wr_idx == AW'(gi));
        end
    endgenerate

    // Storage carries no reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (entry_we[i]) begin
                mem_q[i] <= wdata_i;
            end
        end
    end

    assign rdata_o = mem_q[rd_idx];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

endmodule

// File: rtl/uarttx.sv
// -----------------------------------------------------------------------------
// uarttx
// Memory-mapped 8N1 UART transmitter on the CPU data bus.
//   BASE+0 lane 0 : DATA write pushes a byte into the TX FIFO
//   BASE+0 lane 1 : CTRL  bit0 TXEN, bit1 IE, bit7 write-1 clears OVF
//                   (with UARTTX_PARITY_EN also bit2 PEN, bit3 ODD)
//   BASE+0 read   : {CTRL, STATUS}  STATUS bit0 not-full, bit1 empty,
//                   bit2 shifter idle, bit3 OVF (sticky)
//   BASE+2        : DIV, bit time = DIV+1 clocks, lanes written independently
// Optional feature macro: UARTTX_PARITY_EN (parity bit between DATA and STOP).
// Ports:
//   clk         - system clock
//   reset       - asynchronous, active-low
//   dread_addr  - CPU read address
//   dread_data  - registered read data, valid one cycle after dread_addr
//   dwrite_addr - CPU write address
//   dwrite_data - write data, lane 0 = [7:0], lane 1 = [15:8]
//   dwrite_en   - byte-lane write enables
//   txd         - serial output, idle high
//   interrupt   - IE & FIFO empty, registered
// -----------------------------------------------------------------------------
module uarttx
    import uarttx_pkg::*;
#(
    parameter logic [15:0] BASE       = 16'h0040,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] dread_addr,
    output logic [15:0] dread_data,
    input  logic [15:0] dwrite_addr,
    input  logic [15:0] dwrite_data,
    input  logic [1:0]  dwrite_en,
    output logic        txd,
    output logic        interrupt
);

    // ---------------------------------------------------------------- decode
    logic wr_hit, rd_hit;
    logic push_req, ctrl_we, div_lo_we, div_hi_we;

    assign wr_hit    = (dwrite_addr[15:2] == BASE[15:2]);
    assign rd_hit    = (dread_addr[15:2]  == BASE[15:2]);
    assign push_req  = wr_hit && (dwrite_addr[1] == OFF_DATA) && dwrite_en[0];
    assign ctrl_we   = wr_hit && (dwrite_addr[1] == OFF_DATA) && dwrite_en[1];
    assign div_lo_we = wr_hit && (dwrite_addr[1] == OFF_DIV)  && dwrite_en[0];
    assign div_hi_we = wr_hit && (dwrite_addr[1] == OFF_DIV)  && dwrite_en[1];

    // Byte address bit 0 plays no part in decode.
    logic unused_addr_bits;
    assign unused_addr_bits = dread_addr[0] ^ dwrite_addr[0];

    // ------------------------------------------------------------------ FIFO
    logic       fifo_pop, fifo_full, fifo_empty;
    logic [7:0] fifo_rdata;

    uarttx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push_req),
        .pop_i   (fifo_pop),
        .wdata_i (dwrite_data[7:0]),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // ------------------------------------------------------------- registers
    logic        txen_q, txen_d;
    logic        ie_q, ie_d;
    logic        ovf_q, ovf_d;
    logic [15:0] div_q, div_d;
`ifdef UARTTX_PARITY_EN
    logic        pen_q, pen_d;
    logic        odd_q, odd_d;
`endif

    always_comb begin
        txen_d = txen_q;
        ie_d   = ie_q;
        div_d  = div_q;
        ovf_d  = ovf_q;
`ifdef UARTTX_PARITY_EN
        pen_d  = pen_q;
        odd_d  = odd_q;
`endif
        if (ctrl_we) begin
            txen_d = dwrite_data[8 + CTRL_TXEN];
            ie_d   = dwrite_data[8 + CTRL_IE];
`ifdef UARTTX_PARITY_EN
            pen_d  = dwrite_data[8 + CTRL_PEN];
            odd_d  = dwrite_data[8 + CTRL_ODD];
`endif
        end
        if (div_lo_we) begin
            div_d[7:0] = dwrite_data[7:0];
        end
        if (div_hi_we) begin
            div_d[15:8] = dwrite_data[15:8];
        end
        if (ctrl_we && dwrite_data[8 + CTRL_OVF_CLR]) begin
            ovf_d = 1'b0;
        end
        // A fresh overflow in the same cycle as a clear still gets recorded.
        if (push_req && fifo_full && !fifo_pop) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            txen_q <= 1'b0;
            ie_q   <= 1'b0;
            ovf_q  <= 1'b0;
            div_q  <= 16'h0000;
        end else begin
            txen_q <= txen_d;
            ie_q   <= ie_d;
            ovf_q  <= ovf_d;
            div_q  <= div_d;
        end
    end

`ifdef UARTTX_PARITY_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pen_q <= 1'b0;
            odd_q <= 1'b0;
        end else begin
            pen_q <= pen_d;
            odd_q <= odd_d;
        end
    end
`endif

    // ------------------------------------------------------------------- FSM
    tx_state_e   state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  shift_q, shift_d;
    logic        txd_q, txd_d;
    logic        can_start, bit_done, frame_start;
`ifdef UARTTX_PARITY_EN
    logic        frame_pen_q, frame_odd_q;
`endif

    assign can_start = txen_q && !fifo_empty;
    assign bit_done  = (cnt_q == 16'd0);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        shift_d     = shift_q;
        txd_d       = 1'b1;
        frame_start = 1'b0;
        fifo_pop    = 1'b0;

        // Bit timer: reloading from the live DIV at every boundary lets a
        // mid-frame DIV change take effect from the next bit.
        if (state_q != ST_IDLE) begin
            cnt_d = bit_done ? div_q : cnt_q - 16'd1;
        end

        case (state_q)
            ST_IDLE: begin
                txd_d = 1'b1;
                if (can_start) begin
                    frame_start = 1'b1;
                end
            end
            ST_START: begin
                txd_d = 1'b0;
                if (bit_done) begin
                    state_d = ST_DATA;
                    idx_d   = 3'd0;
                end
            end
            ST_DATA: begin
                txd_d = shift_q[idx_q];
                if (bit_done) begin
                    idx_d = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
`ifdef UARTTX_PARITY_EN
                        state_d = frame_pen_q ? ST_PARITY : ST_STOP;
`else
                        state_d = ST_STOP;
`endif
                    end
                end
            end
`ifdef UARTTX_PARITY_EN
            ST_PARITY: begin
                txd_d = parity_of(shift_q, frame_odd_q);
                if (bit_done) begin
                    state_d = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                txd_d = 1'b1;
                if (bit_done) begin
                    // Chain straight into the next frame so queued bytes go
                    // out with no idle gap between stop and start bits.
                    if (can_start) begin
                        frame_start = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (frame_start) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_rdata;
            cnt_d    = div_q;
            idx_d    = 3'd0;
            state_d  = ST_START;
        end
    end

    // txd is registered from the current state, so the line trails the FSM
    // by one clock; every bit still lasts exactly DIV+1 clocks.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 16'd0;
            idx_q   <= 3'd0;
            shift_q <= 8'd0;
            txd_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            txd_q   <= txd_d;
        end
    end

`ifdef UARTTX_PARITY_EN
    // Parity mode is frozen for the whole frame at the pop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frame_pen_q <= 1'b0;
            frame_odd_q <= 1'b0;
        end else if (frame_start) begin
            frame_pen_q <= pen_q;
            frame_odd_q <= odd_q;
        end
    end
`endif

    // ----------------------------------------------------- read and interrupt
    logic [7:0]  status, ctrl_rd;
    logic [15:0] rdata_q, rdata_d;
    logic        irq_q, irq_d;

    always_comb begin
        status                = 8'h00;
        status[STAT_NOT_FULL] = ~fifo_full;
        status[STAT_EMPTY]    = fifo_empty;
        status[STAT_IDLE]     = (state_q == ST_IDLE);
        status[STAT_OVF]      = ovf_q;

        ctrl_rd               = 8'h00;
        ctrl_rd[CTRL_TXEN]    = txen_q;
        ctrl_rd[CTRL_IE]      = ie_q;
`ifdef UARTTX_PARITY_EN
        ctrl_rd[CTRL_PEN]     = pen_q;
        ctrl_rd[CTRL_ODD]     = odd_q;
`endif

        rdata_d = 16'h0000;
        if (rd_hit) begin
            rdata_d = (dread_addr[1] == OFF_DIV) ? div_q : {ctrl_rd, status};
        end

        irq_d = ie_q & fifo_empty;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata_q <= 16'h0000;
            irq_q   <= 1'b0;
        end else begin
            rdata_q <= rdata_d;
            irq_q   <= irq_d;
        end
    end

    assign dread_data = rdata_q;
    assign txd        = txd_q;
    assign interrupt  = irq_q;

endmodule

// File: tb/tb_uarttx.sv
`timescale 1ns/1ps
module tb_uarttx;

    localparam logic [15:0] BASE = 16'h0040;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] dread_addr = 16'h0000;
    logic [15:0] dread_data;
    logic [15:0] dwrite_addr = 16'h0000;
    logic [15:0] dwrite_data = 16'h0000;
    logic [1:0]  dwrite_en = 2'b00;
    logic        txd;
    logic        interrupt;

    always #5 clk = ~clk;

    uarttx #(
        .BASE       (BASE),
        .FIFO_DEPTH (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .dread_addr  (dread_addr),
        .dread_data  (dread_data),
        .dwrite_addr (dwrite_addr),
        .dwrite_data (dwrite_data),
        .dwrite_en   (dwrite_en),
        .txd         (txd),
        .interrupt   (interrupt)
    );

    // Scoreboard: one entry per expected txd clock of every queued frame.
    typedef struct packed {
        logic val;
        logic last;
    } exp_bit_t;

    exp_bit_t exp_q[$];
    int       start_cyc[$];
    int       checks = 0;
    int       errors = 0;
    int       cyc = 0;
    bit       mon_active = 0;

    // Model of the programmed configuration.
    int       cur_div = 0;
    bit       cur_pen = 0;
    bit       cur_odd = 0;

    // Line monitor: a start bit pulls frames off the scoreboard clock by clock.
    initial begin : monitor
        exp_bit_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (!reset) begin
                exp_q.delete();
                mon_active = 0;
            end else begin
                if (!mon_active && txd === 1'b0) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_start: txd=%b at cycle %0d, required idle 1", txd, cyc);
                    end else begin
                        mon_active = 1;
                        start_cyc.push_back(cyc);
                    end
                end
                if (mon_active) begin
                    e = exp_q.pop_front();
                    checks++;
                    if (txd !== e.val) begin
                        errors++;
                        $display("FAIL txd_bit: got %b, expected %b at cycle %0d", txd, e.val, cyc);
                    end
                    if (e.last) mon_active = 0;
                end
            end
        end
    end

    initial begin : watchdog
        #1ms;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------ bus tasks
    task automatic bus_write(input logic [15:0] addr, input logic [15:0] data, input logic [1:0] en);
        @(negedge clk);
        dwrite_addr = addr;
        dwrite_data = data;
        dwrite_en   = en;
        @(negedge clk);
        dwrite_en   = 2'b00;
    endtask

    task automatic bus_read(input logic [15:0] addr, output logic [15:0] data);
        @(negedge clk);
        dread_addr = addr;
        @(negedge clk);
        data = dread_data;
    endtask

    task automatic expect_frame(input logic [7:0] d);
        logic     bits[$];
        exp_bit_t e;
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(d[i]);
`ifdef UARTTX_PARITY_EN
        if (cur_pen) bits.push_back((^d) ^ cur_odd);
`endif
        bits.push_back(1'b1);
        for (int b = 0; b < bits.size(); b++) begin
            for (int r = 0; r <= cur_div; r++) begin
                e.val  = bits[b];
                e.last = (b == bits.size() - 1) && (r == cur_div);
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic write_ctrl(input logic [7:0] c);
        cur_pen = c[2];
        cur_odd = c[3];
        bus_write(BASE, {c, 8'h00}, 2'b10);
    endtask

    task automatic write_div(input logic [15:0] d);
        cur_div = int'(d);
        bus_write(BASE + 16'd2, d, 2'b11);
    endtask

    task automatic write_data(input logic [7:0] d, input bit accepted);
        if (accepted) expect_frame(d);
        bus_write(BASE, {8'h00, d}, 2'b01);
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || mon_active) && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0 || mon_active) begin
            errors++;
            $display("FAIL drain_timeout: %0d expected bit-clocks left, required 0", exp_q.size());
        end
        repeat (3) @(negedge clk);
    endtask

    // ---------------------------------------------------------------- tests
    task automatic test_reset();
        logic [15:0] d;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (dread_data !== 16'h0000) begin
            errors++; $display("FAIL reset_dread_data: got %h, expected 0000", dread_data);
        end
        checks++;
        if (txd !== 1'b1) begin
            errors++; $display("FAIL reset_txd: got %b, expected 1", txd);
        end
        checks++;
        if (interrupt !== 1'b0) begin
            errors++; $display("FAIL reset_interrupt: got %b, expected 0", interrupt);
        end
        reset = 1'b1;
        bus_read(BASE, d);
        checks++;
        if (d !== 16'h0007) begin
            errors++; $display("FAIL reset_status: got %h, expected 0007", d);
        end
        bus_read(BASE + 16'd2, d);
        checks++;
        if (d !== 16'h0000) begin
            errors++; $display("FAIL reset_div: got %h, expected 0000", d);
        end
    endtask

    task automatic test_frame();
        logic [15:0] d;
        write_div(16'd3);
        bus_read(BASE + 16'd2, d);
        checks++;
        if (d !== 16'h0003) begin
            errors++; $display("FAIL div_read: got %h, expected 0003", d);
        end
        bus_read(BASE + 16'd3, d);
        checks++;
        if (d !== 16'h0003) begin
            errors++; $display("FAIL div_read_addr0_ignored: got %h, expected 0003", d);
        end
        bus_read(BASE + 16'd4, d);
        checks++;
        if (d !== 16'h0000) begin
            errors++; $display("FAIL out_of_block_read: got %h, expected 0000", d);
        end
        // Lane independence: rewrite only the high byte of DIV.
        bus_write(BASE + 16'd2, 16'h12FF, 2'b10);
        bus_read(BASE + 16'd2, d);
        checks++;
        if (d !== 16'h1203) begin
            errors++; $display("FAIL div_lane_hi: got %h, expected 1203", d);
        end
        write_div(16'd3);
        write_ctrl(8'h01);
        write_data(8'h55, 1);
        // Back at the first negedge after the write edge.
        checks++;
        if (txd !== 1'b1) begin
            errors++; $display("FAIL start_latency_e0: got %b, expected 1", txd);
        end
        @(negedge clk);
        checks++;
        if (txd !== 1'b1) begin
            errors++; $display("FAIL start_latency_e1: got %b, expected 1", txd);
        end
        @(negedge clk);
        checks++;
        if (txd !== 1'b0) begin
            errors++; $display("FAIL start_latency_e2: got %b, expected 0", txd);
        end
        wait_drain(100);
    endtask

    task automatic test_overflow_back_to_back();
        logic [15:0] d;
        logic [7:0]  bytes [4];
        bytes[0] = 8'hA1; bytes[1] = 8'h3C; bytes[2] = 8'hF0; bytes[3] = 8'h0F;
        write_ctrl(8'h00);
        for (int i = 0; i < 4; i++) write_data(bytes[i], 1);
        bus_read(BASE, d);
        checks++;
        if (d !== 16'h0004) begin
            errors++; $display("FAIL fifo_full_status: got %h, expected 0004", d);
        end
        write_data(8'hEE, 0);
        bus_read(BASE, d);
        checks++;
        if (d !== 16'h000C) begin
            errors++; $display("FAIL overflow_status: got %h, expected 000c", d);
        end
        write_ctrl(8'h80);
        bus_read(BASE, d);
        checks++;
        if (d !== 16'h0004) begin
            errors++; $display("FAIL ovf_clear_status: got %h, expected 0004", d);
        end
        start_cyc.delete();
        write_ctrl(8'h01);
        wait_drain(400);
        checks++;
        if (start_cyc.size() != 4) begin
            errors++; $display("FAIL frame_count: got %0d, expected 4", start_cyc.size());
        end else begin
            for (int k = 1; k < 4; k++) begin
                checks++;
                if (start_cyc[k] - start_cyc[k-1] != 10 * (cur_div + 1)) begin
                    errors++;
                    $display("FAIL back_to_back_spacing: got %0d, expected %0d", start_cyc[k] - start_cyc[k-1], 10 * (cur_div + 1));
                end
            end
        end
    endtask

    task automatic test_interrupt();
        logic [15:0] d;
        write_ctrl(8'h03);
        @(negedge clk);
        checks++;
        if (interrupt !== 1'b1) begin
            errors++; $display("FAIL irq_enable: got %b, expected 1", interrupt);
        end
        write_data(8'h5A, 1);
        checks++;
        if (interrupt !== 1'b1) begin
            errors++; $display("FAIL irq_push_lag: got %b, expected 1", interrupt);
        end
        @(negedge clk);
        checks++;
        if (interrupt !== 1'b0) begin
            errors++; $display("FAIL irq_after_push: got %b, expected 0", interrupt);
        end
        @(negedge clk);
        checks++;
        if (interrupt !== 1'b1) begin
            errors++; $display("FAIL irq_after_pop: got %b, expected 1", interrupt);
        end
        bus_read(BASE, d);
        checks++;
        if (d !== 16'h0303) begin
            errors++; $display("FAIL busy_status: got %h, expected 0303", d);
        end
        checks++;
        if (interrupt !== 1'b1) begin
            errors++; $display("FAIL irq_while_sending: got %b, expected 1", interrupt);
        end
        wait_drain(100);
        checks++;
        if (interrupt !== 1'b1) begin
            errors++; $display("FAIL irq_after_frame: got %b, expected 1", interrupt);
        end
    endtask

    task automatic test_parity();
        logic [15:0] d;
        logic [15:0] exp_rd;
        write_div(16'd0);
        write_ctrl(8'h0D);
        write_data(8'h01, 1);
        wait_drain(60);
        bus_read(BASE, d);
`ifdef UARTTX_PARITY_EN
        exp_rd = 16'h0D07;
`else
        exp_rd = 16'h0107;
`endif
        checks++;
        if (d !== exp_rd) begin
            errors++; $display("FAIL parity_ctrl_read: got %h, expected %h", d, exp_rd);
        end
        write_ctrl(8'h05);
        write_data(8'h01, 1);
        write_data(8'hB7, 1);
        wait_drain(80);
    endtask

    task automatic test_reset_mid_frame();
        logic [15:0] d;
        write_div(16'd3);
        write_ctrl(8'h01);
        write_data(8'hA5, 1);
        repeat (12) @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (txd !== 1'b1) begin
            errors++; $display("FAIL reset_mid_frame_txd: got %b, expected 1", txd);
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        cur_div = 0; cur_pen = 0; cur_odd = 0;
        bus_read(BASE, d);
        checks++;
        if (d !== 16'h0007) begin
            errors++; $display("FAIL reset_mid_frame_status: got %h, expected 0007", d);
        end
        repeat (60) @(negedge clk);
        checks++;
        if (txd !== 1'b1) begin
            errors++; $display("FAIL residual_frame: txd got %b, expected 1", txd);
        end
    endtask

    initial begin : main
        test_reset();
        test_frame();
        test_overflow_back_to_back();
        test_interrupt();
        test_parity();
        test_reset_mid_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
